// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF engine: races oscillator pairs over a clk window
// and turns each pair's edge-count comparison into one response bit.
module ro_puf_engine #(
  parameter int NUM_RO    = 16,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16,
  parameter int RESP_BITS = 8,
  localparam int SEL_W    = $clog2(NUM_RO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SEL_W-1:0]     seed,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [NUM_RO-1:0]    ro_in,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic                 tie
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_COUNT, S_CMP, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [SEL_W-1:0] KLAST = SEL_W'(RESP_BITS - 1);
  localparam logic [WIN_W-1:0] SETTLE_N = WIN_W'(2);

  state_t           state;
  logic [SEL_W-1:0] seed_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] tmr;
  logic [SEL_W-1:0] k;
  logic [SEL_W-1:0] k2;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       pv;
  logic [1:0]       edg;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  // Pair k uses oscillators seed+2k and seed+2k+1, wrapping mod NUM_RO
  assign k2    = k << 1;
  assign sel_a = seed_q + k2;
  assign sel_b = sel_a + SEL_W'(1);
  assign edg   = s2 & ~pv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      seed_q   <= '0;
      win_q    <= '0;
      tmr      <= '0;
      k        <= '0;
      ro_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      tie      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SETTLE;
            seed_q   <= seed;
            win_q    <= win_len;
            response <= '0;
            tie      <= 1'b0;
            k        <= '0;
            tmr      <= SETTLE_N;
            busy     <= 1'b1;
            ro_en    <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (tmr == '0) begin
            state <= S_COUNT;
            tmr   <= (win_q == '0) ? '0 : win_q - WIN_W'(1);
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        S_COUNT: begin
          if (tmr == '0) begin
            state <= S_CMP;
            ro_en <= 1'b0;
          end else begin
            tmr <= tmr - WIN_W'(1);
          end
        end
        S_CMP: begin
          if (cnt_a > cnt_b)
            response <= response | (RESP_BITS'(1) << k);
          if (cnt_a == cnt_b)
            tie <= 1'b1;
          if (k == KLAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            k     <= k + SEL_W'(1);
            state <= S_SETTLE;
            tmr   <= SETTLE_N;
            ro_en <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Counters read zero outside COUNT so each pair starts from a clean slate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      pv    <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      s1 <= {ro_in[sel_b], ro_in[sel_a]};
      s2 <= s1;
      pv <= s2;
      if (state == S_COUNT) begin
        if (edg[0] && cnt_a != CMAX)
          cnt_a <= cnt_a + CNT_W'(1);
        if (edg[1] && cnt_b != CMAX)
          cnt_b <= cnt_b + CNT_W'(1);
      end else begin
        cnt_a <= '0;
        cnt_b <= '0;
      end
    end
  end

endmodule
